// File: rtl/ts_cbs_mq.sv
// Multi-queue credit-based shaper: one signed credit counter and programmable
// idle slope per traffic class, gating each queue's valid toward the egress arbiter.
module ts_cbs_mq #(
  parameter int NUM_QUEUES     = 4,
  parameter int CREDIT_W       = 20,
  parameter int SLOPE_W        = 16,
  parameter int TICK_CYCLES    = 125,
  parameter int PORT_RATE      = 100,
  parameter int IDLE_SLOPE_RST = 20,
  parameter int HI_CREDIT      = 4096,
  parameter int LO_CREDIT      = -4096
) (
  input  logic                           axis_aclk,
  input  logic                           axis_reset,
  input  logic [NUM_QUEUES-1:0]          q_tvalid,
  input  logic [NUM_QUEUES-1:0]          q_tready,
  input  logic [NUM_QUEUES-1:0]          q_tlast,
  input  logic [NUM_QUEUES-1:0]          shaper_en,
  input  logic                           cfg_we,
  input  logic [2:0]                     cfg_queue,
  input  logic [SLOPE_W-1:0]             cfg_idle_slope,
  output logic [NUM_QUEUES-1:0]          queue_valid,
  output logic [NUM_QUEUES*CREDIT_W-1:0] credit_flat
);

  localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned SUM_W = CREDIT_W + 2;

  localparam logic signed [SUM_W-1:0]    HI_SUM   = SUM_W'(HI_CREDIT);
  localparam logic signed [SUM_W-1:0]    LO_SUM   = SUM_W'(LO_CREDIT);
  localparam logic signed [SUM_W-1:0]    RATE_SUM = SUM_W'(PORT_RATE);
  localparam logic signed [SUM_W-1:0]    ZERO_SUM = '0;
  localparam logic [CNT_W-1:0]           CNT_LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0]           r_tick_cnt;
  logic                       w_tick;
  logic [NUM_QUEUES-1:0]      r_in_frame;
  logic signed [CREDIT_W-1:0] r_credit     [NUM_QUEUES];
  logic [SLOPE_W-1:0]         r_slope      [NUM_QUEUES];
  logic signed [CREDIT_W-1:0] w_credit_nxt [NUM_QUEUES];
  logic signed [SUM_W-1:0]    w_slope_ext  [NUM_QUEUES];
  logic signed [SUM_W-1:0]    w_sum_up     [NUM_QUEUES];
  logic signed [SUM_W-1:0]    w_sum_tx     [NUM_QUEUES];
  logic [NUM_QUEUES-1:0]      w_tx_active;
  logic [SLOPE_W-1:0]         w_cfg_val;

  assign w_tick = (r_tick_cnt == CNT_LAST);

  // Free-running tick divider
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + CNT_W'(1);
    end
  end

  // Frame tracking: a started multi-beat frame stays ungated until tlast
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      r_in_frame <= '0;
    end else begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
        if (q_tvalid[i] && q_tready[i]) begin
          r_in_frame[i] <= ~q_tlast[i];
        end
      end
    end
  end

  assign w_cfg_val = (32'(cfg_idle_slope) > 32'(PORT_RATE)) ? SLOPE_W'(PORT_RATE)
                                                           : cfg_idle_slope;

  // Idle-slope registers; out-of-range queue indices never match
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
        r_slope[i] <= SLOPE_W'(IDLE_SLOPE_RST);
      end
    end else begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
        if (cfg_we && (cfg_queue == 3'(i))) begin
          r_slope[i] <= w_cfg_val;
        end
      end
    end
  end

  // Next credit per queue, sums carried two bits wide to detect bound crossings
  always_comb begin
    for (int i = 0; i < NUM_QUEUES; i++) begin
      w_slope_ext[i]  = SUM_W'(r_slope[i]);
      w_sum_up[i]     = SUM_W'(r_credit[i]) + w_slope_ext[i];
      w_sum_tx[i]     = w_sum_up[i] - RATE_SUM;
      w_tx_active[i]  = r_in_frame[i] | (q_tvalid[i] & q_tready[i]);
      w_credit_nxt[i] = r_credit[i];
      if (!shaper_en[i]) begin
        w_credit_nxt[i] = '0;
      end else if (w_tx_active[i]) begin
        w_credit_nxt[i] = (w_sum_tx[i] < LO_SUM) ? CREDIT_W'(LO_CREDIT)
                                                 : CREDIT_W'(w_sum_tx[i]);
      end else if (q_tvalid[i]) begin
        w_credit_nxt[i] = (w_sum_up[i] > HI_SUM) ? CREDIT_W'(HI_CREDIT)
                                                 : CREDIT_W'(w_sum_up[i]);
      end else if (w_sum_up[i] > ZERO_SUM) begin
        w_credit_nxt[i] = '0;
      end else begin
        w_credit_nxt[i] = CREDIT_W'(w_sum_up[i]);
      end
    end
  end

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
        r_credit[i] <= '0;
      end
    end else if (w_tick) begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
        r_credit[i] <= w_credit_nxt[i];
      end
    end
  end

  // Valid gating is combinational so q_tvalid sees no added latency
  always_comb begin
    queue_valid = '0;
    credit_flat = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      queue_valid[i] = q_tvalid[i] &
                       (~shaper_en[i] | r_in_frame[i] | ~r_credit[i][CREDIT_W-1]);
      credit_flat[i*CREDIT_W +: CREDIT_W] = r_credit[i];
    end
  end

endmodule
